riscv_hazard_ctrl: RTL



---
 rtl/riscv_hazard_ctrl_pkg.sv | 45 ++++
 rtl/riscv_fwd_cmp.sv | 31 +++
 rtl/riscv_hazard_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
//   fwd_sel_e   : forwarding select in front of the EX operand muxes
//   op2_sel_e   : ALU operand-2 source select
//   ex_slot_t   : shadow copy of the instruction occupying EX
//   pipe_slot_t : shadow copy of the instruction occupying MEM or WB
package riscv_hazard_ctrl_pkg;

    localparam int REG_AW_P = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [0:0] {
        OP2_REG = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    typedef struct packed {
        logic                valid;
        logic [REG_AW_P-1:0] rs1;
        logic [REG_AW_P-1:0] rs2;
        logic                rs1_used;
        logic                rs2_used;
        logic [REG_AW_P-1:0] rd;
        logic                wen;
        logic                load;
    } ex_slot_t;

    typedef struct packed {
        logic                valid;
        logic [REG_AW_P-1:0] rd;
        logic                wen;
        logic                load;
    } pipe_slot_t;

    // A slot can supply a forwarded value only if it really writes a
    // register other than x0.
    function automatic logic writes_reg(input pipe_slot_t s);
        return s.valid && s.wen && (s.rd != '0);
    endfunction

endpackage

// File: rtl/riscv_fwd_cmp.sv
// Per-operand forwarding compare: picks MEM over WB over register file.
//   src_used : EX instruction is valid and reads this operand
//   src_addr : EX source register address
//   mem_slot : instruction currently in MEM
//   wb_slot  : instruction currently in WB
//   sel      : resulting forwarding select
module riscv_fwd_cmp
    import riscv_hazard_ctrl_pkg::*;
(
    input  logic                src_used,
    input  logic [REG_AW_P-1:0] src_addr,
    input  pipe_slot_t          mem_slot,
    input  pipe_slot_t          wb_slot,
    output fwd_sel_e            sel
);

    // Load flags are not needed here: the interlock keeps a load out of MEM
    // while its consumer is in EX, and a load in WB forwards like an ALU op.
    logic unused_load;
    assign unused_load = mem_slot.load ^ wb_slot.load;

    always_comb begin
        sel = FWD_REG;
        if (src_used && writes_reg(mem_slot) && (mem_slot.rd == src_addr)) begin
            sel = FWD_MEM;
        end else if (src_used && writes_reg(wb_slot) && (wb_slot.rd == src_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks rd/wen/load of the instructions in EX, MEM and WB and drives the
// ALU forwarding selects, the one-cycle load-use interlock and flush bubbles.
//   clk, rst      : core clock, async active-high reset
//   id_*          : decoded fields of the instruction in ID
//   flush         : taken branch/jump resolved in EX, kills the ID instruction
//   stall         : hold PC and IF/ID this cycle
//   fwd_a_sel/b   : forwarding selects for EX operand 1 / rs2 data
//   stall_cnt     : saturating count of load-use stall cycles
module riscv_hazard_ctrl
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int XLEN_CNT = 32,
    parameter int REG_AW   = REG_AW_P  // slot structs are sized by REG_AW_P
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1_addr,
    input  logic [REG_AW-1:0]   id_rs2_addr,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd_addr,
    input  logic                id_rd_wen,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output fwd_sel_e            fwd_a_sel,
    output fwd_sel_e            fwd_b_sel,
    output logic [XLEN_CNT-1:0] stall_cnt
);

    ex_slot_t   ex_slot;
    pipe_slot_t mem_slot;
    pipe_slot_t wb_slot;

    logic ex_load_pending;
    logic rs1_hit;
    logic rs2_hit;

    assign ex_load_pending = ex_slot.valid && ex_slot.load && ex_slot.wen
                             && (ex_slot.rd != '0);
    assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_slot.rd);
    assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_slot.rd);

    // Flush wins: the ID instruction is being killed, so it cannot stall.
    assign stall = id_valid && !flush && ex_load_pending && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            stall_cnt <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= '{valid: ex_slot.valid, rd: ex_slot.rd,
                          wen: ex_slot.wen, load: ex_slot.load};
            if (flush || stall) begin
                ex_slot <= '0;
            end else begin
                ex_slot <= '{valid:    id_valid,
                             rs1:      id_rs1_addr,
                             rs2:      id_rs2_addr,
                             rs1_used: id_rs1_used,
                             rs2_used: id_rs2_used,
                             rd:       id_rd_addr,
                             wen:      id_rd_wen,
                             load:     id_is_load};
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + XLEN_CNT'(1);
            end
        end
    end

    riscv_fwd_cmp u_fwd_a (
        .src_used (ex_slot.valid && ex_slot.rs1_used),
        .src_addr (ex_slot.rs1),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .sel      (fwd_a_sel)
    );

    riscv_fwd_cmp u_fwd_b (
        .src_used (ex_slot.valid && ex_slot.rs2_used),
        .src_addr (ex_slot.rs2),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .sel      (fwd_b_sel)
    );

endmodule
